digit_overlay: RTL and testbench

- Parameterised, register-backed seven-segment digit overlay for the LCD/VGA pixel path. It replaces the approach of one hard-wired digit instance per input bus.
- Holds NUM_DIGITS digit descriptors that software writes through a simple write port. The digits are laid out in one row at a fixed pitch.
- Renders the digits into a 3-bit rgb stream with per-digit colour, enable and hardware blink.
- Sits between the sync generator (pix_x, pix_y, video_on) and the rgb mux feeding the LCD.

---
 rtl/digit_overlay.sv | 213 +++++++++++++++++++++
 tb/tb_digit_overlay.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/digit_overlay.sv
// Seven-segment digit overlay for the pixel path.
// A small register file holds one descriptor per digit slot; the current
// pixel is classified in stage 1 (row hit, slot index, local x/y) and
// turned into a colour in stage 2, giving a fixed two-cycle latency from
// pix_x/pix_y/video_on to rgb_menu.
//
// Write port: wr_en is a single-cycle strobe with no back-pressure; the
// descriptor is captured on the rising edge where wr_en is high, and
// addresses at or beyond NUM_DIGITS are dropped.
module digit_overlay #(
  parameter int         NUM_DIGITS   = 8,
  parameter int         X0           = 64,
  parameter int         Y0           = 100,
  parameter int         PITCH_LOG2   = 4,
  parameter int         DIG_W        = 12,
  parameter int         DIG_H        = 20,
  parameter int         SEG_T        = 2,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [2:0] BG_RGB       = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_on,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [8:0] wr_data,
  output logic [2:0] rgb_menu
);

  // Row extents, widened by one bit so X0 + row width cannot wrap.
  localparam int          X_END    = X0 + (NUM_DIGITS << PITCH_LOG2);
  localparam logic [10:0] X_LO_L   = 11'(X0);
  localparam logic [10:0] X_HI_L   = 11'(X_END);
  localparam logic [10:0] Y_LO_L   = 11'(Y0);
  localparam logic [10:0] Y_HI_L   = 11'(Y0 + DIG_H);
  localparam logic [9:0]  X0_L     = 10'(X0);
  localparam logic [9:0]  Y0_L     = 10'(Y0);

  // Segment band boundaries in local digit coordinates.
  localparam logic [9:0]  SEG_T_L  = 10'(SEG_T);
  localparam logic [9:0]  DIG_W_L  = 10'(DIG_W);
  localparam logic [9:0]  RIGHT_L  = 10'(DIG_W - SEG_T);
  localparam logic [9:0]  BOT_L    = 10'(DIG_H - SEG_T);
  localparam logic [9:0]  HALF_L   = 10'(DIG_H / 2);
  localparam logic [9:0]  G_LO_L   = 10'(DIG_H / 2 - SEG_T / 2);
  localparam logic [9:0]  G_HI_L   = 10'(DIG_H / 2 + SEG_T / 2);

  // Blink counter sized to hold 0 .. BLINK_FRAMES-1.
  localparam int             CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // Standard hex-to-seven-segment table, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // Descriptor file: {blink, en, color[2:0], value[3:0]} per slot.
  // ---------------------------------------------------------------------
  logic [8:0] desc [NUM_DIGITS];

  // Store a descriptor on a write strobe; out-of-range slots are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) desc[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_addr == 4'(i)) desc[i] <= wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Blink timing: count frame starts, toggle phase every BLINK_FRAMES.
  // ---------------------------------------------------------------------
  logic             origin;
  logic             origin_q;
  logic             frame_start;
  logic [CNT_W-1:0] frame_cnt;
  logic             blink_phase;

  // Frame start is the rising edge of "pixel is at (0,0)", so a coordinate
  // held for several cycles counts as one frame.
  always_comb begin
    origin      = (pix_x == 10'd0) && (pix_y == 10'd0);
    frame_start = origin && !origin_q;
  end

  // Frame counter and blink phase; phase 0 means blinking digits are shown.
  always_ff @(posedge clk) begin
    if (reset) begin
      origin_q    <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      origin_q <= origin;
      if (frame_start) begin
        if (frame_cnt == CNT_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: locate the pixel relative to the digit row.
  // ---------------------------------------------------------------------
  logic                  in_row;
  logic                  s1_video;
  logic                  s1_in_row;
  logic [3:0]            s1_idx;
  logic [PITCH_LOG2-1:0] s1_lx;
  logic [9:0]            s1_ly;

  // Row membership test; the slot index/local coordinates are only
  // meaningful when this is true.
  always_comb begin
    in_row = ({1'b0, pix_y} >= Y_LO_L) && ({1'b0, pix_y} < Y_HI_L) &&
             ({1'b0, pix_x} >= X_LO_L) && ({1'b0, pix_x} < X_HI_L);
  end

  // Register the pixel classification for stage 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_video  <= 1'b0;
      s1_in_row <= 1'b0;
      s1_idx    <= '0;
      s1_lx     <= '0;
      s1_ly     <= '0;
    end else begin
      s1_video  <= video_on;
      s1_in_row <= in_row;
      s1_idx    <= 4'((pix_x - X0_L) >> PITCH_LOG2);
      s1_lx     <= PITCH_LOG2'(pix_x - X0_L);
      s1_ly     <= pix_y - Y0_L;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: descriptor lookup, segment hit, colour select.
  // ---------------------------------------------------------------------
  logic [8:0] rd_desc;
  logic [9:0] lx;
  logic [6:0] geom;
  logic [6:0] lit;
  logic       seg_hit;
  logic       show;

  // Select the descriptor for the slot under the pixel; unused index
  // values read as a disabled digit.
  always_comb begin
    rd_desc = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s1_idx == 4'(i)) rd_desc = desc[i];
    end
  end

  // Which segment regions contain the local pixel, and whether any of
  // them is lit for this digit's value.
  always_comb begin
    lx      = 10'(s1_lx);
    geom[0] = s1_ly < SEG_T_L;                             // a
    geom[1] = (lx >= RIGHT_L) && (s1_ly < HALF_L);         // b
    geom[2] = (lx >= RIGHT_L) && (s1_ly >= HALF_L);        // c
    geom[3] = s1_ly >= BOT_L;                              // d
    geom[4] = (lx < SEG_T_L) && (s1_ly >= HALF_L);         // e
    geom[5] = (lx < SEG_T_L) && (s1_ly < HALF_L);          // f
    geom[6] = (s1_ly >= G_LO_L) && (s1_ly < G_HI_L);       // g
    lit     = seg7(rd_desc[3:0]);
    seg_hit = |(geom & lit);
    show    = s1_in_row && (lx < DIG_W_L) && rd_desc[7] &&
              (!rd_desc[8] || !blink_phase) && seg_hit;
  end

  // Registered output colour: black outside the active area, digit colour
  // on a lit segment, background elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_menu <= 3'b000;
    end else if (!s1_video) begin
      rgb_menu <= 3'b000;
    end else if (show) begin
      rgb_menu <= rd_desc[6:4];
    end else begin
      rgb_menu <= BG_RGB;
    end
  end

endmodule

// File: tb/tb_digit_overlay.sv
// Bench for digit_overlay with default parameters.
module tb_digit_overlay;

  logic       clk;
  logic       reset;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [8:0] wr_data;
  logic [2:0] rgb_menu;

  digit_overlay dut (
    .clk      (clk),
    .reset    (reset),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .video_on (video_on),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rgb_menu (rgb_menu)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [8:0] ref_desc [8];
  logic [6:0] seg_tab  [16];
  int         frames;
  int         pass_cnt;
  int         total_cnt;

  typedef struct {
    int         x;
    int         y;
    bit         v;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs [14];

  // Expected colour from the pixel rules, using plain integer geometry.
  function automatic logic [2:0] model_rgb(int x, int y, bit v);
    int d, lx, ly;
    logic [8:0] ds;
    logic [6:0] s;
    bit hit;
    if (!v) return 3'b000;
    if (y < 100 || y >= 120 || x < 64 || x >= 64 + 8 * 16) return 3'b000;
    d  = (x - 64) / 16;
    lx = (x - 64) % 16;
    ly = y - 100;
    if (lx >= 12) return 3'b000;
    ds = ref_desc[d];
    if (!ds[7]) return 3'b000;
    if (ds[8] && ((frames / 30) % 2 == 1)) return 3'b000;
    s   = seg_tab[ds[3:0]];
    hit = (s[0] && ly < 2) ||
          (s[1] && lx >= 10 && ly < 10) ||
          (s[2] && lx >= 10 && ly >= 10) ||
          (s[3] && ly >= 18) ||
          (s[4] && lx < 2 && ly >= 10) ||
          (s[5] && lx < 2 && ly < 10) ||
          (s[6] && ly >= 9 && ly < 11);
    return hit ? ds[6:4] : 3'b000;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [2:0] act, logic [2:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: rgb_menu=%b expected %b", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_pix(int x, int y, bit v);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = v;
  endtask

  // Present a pixel and compare the output two cycles later.
  task automatic check_pix(string name, int x, int y, bit v, logic [2:0] exp);
    drive_pix(x, y, v);
    repeat (2) @(posedge clk);
    #1;
    check(name, rgb_menu, exp);
  endtask

  task automatic write_desc(int addr, logic [8:0] data);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (addr < 8) ref_desc[addr] = data;
  endtask

  // One frame start: (0,0) held three cycles, then away from the origin.
  task automatic frame_pulse();
    drive_pix(0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    drive_pix(5, 5, 1'b0);
    @(posedge clk);
    #1;
    frames++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_desc[i] = '0;
    frames = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int x, y, n;
    bit v;
    logic [8:0] d;

    pass_cnt  = 0;
    total_cnt = 0;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();

    // Hand-derived vectors for digit 0 = red 8, digit 1 = cyan-ish 1.
    vecs[0]  = '{64, 100, 1'b1, 3'b100};  // digit 0 segment a
    vecs[1]  = '{70, 110, 1'b1, 3'b100};  // g band
    vecs[2]  = '{67, 105, 1'b1, 3'b000};  // interior
    vecs[3]  = '{80, 100, 1'b1, 3'b000};  // digit 1 unlit a
    vecs[4]  = '{91, 103, 1'b1, 3'b011};  // digit 1 segment b
    vecs[5]  = '{76, 100, 1'b1, 3'b000};  // gap column lx=12
    vecs[6]  = '{64, 100, 1'b0, 3'b000};  // video off
    vecs[7]  = '{64, 119, 1'b1, 3'b100};  // last row, segment d
    vecs[8]  = '{75, 119, 1'b1, 3'b100};  // bottom-right corner
    vecs[9]  = '{64, 120, 1'b1, 3'b000};  // below row
    vecs[10] = '{63, 100, 1'b1, 3'b000};  // left of row
    vecs[11] = '{90, 115, 1'b1, 3'b011};  // digit 1 segment c
    vecs[12] = '{82, 115, 1'b1, 3'b000};  // digit 1, outside e band
    vecs[13] = '{96, 100, 1'b1, 3'b000};  // digit 2 disabled

    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    drive_pix(5, 5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", rgb_menu, 3'b000);
    reset = 1'b0;

    write_desc(0, 9'b0_1_100_1000);
    write_desc(1, 9'b0_1_011_0001);
    for (int i = 0; i < 14; i++)
      check_pix($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].v, vecs[i].exp);

    // Out-of-range write must not touch any slot.
    write_desc(8, 9'h1FF);
    check_pix("oob_digit0", 64, 100, 1'b1, 3'b100);
    for (int k = 1; k < 8; k++) begin
      check_pix($sformatf("oob_a%0d", k), 64 + 16 * k, 100, 1'b1, model_rgb(64 + 16 * k, 100, 1'b1));
      check_pix($sformatf("oob_b%0d", k), 75 + 16 * k, 103, 1'b1, model_rgb(75 + 16 * k, 103, 1'b1));
    end

    // Blink: digit 0 blinks, digit 1 does not.
    write_desc(0, 9'b1_1_100_1000);
    check_pix("blink_on0", 64, 100, 1'b1, 3'b100);
    repeat (29) frame_pulse();
    check_pix("blink_29", 64, 100, 1'b1, 3'b100);
    frame_pulse();
    check_pix("blink_off", 64, 100, 1'b1, 3'b000);
    check_pix("blink_d1_a", 91, 103, 1'b1, 3'b011);
    repeat (30) frame_pulse();
    check_pix("blink_on1", 64, 100, 1'b1, 3'b100);
    check_pix("blink_d1_b", 91, 103, 1'b1, 3'b011);

    // One-cycle video_on pulse appears exactly two cycles later.
    check_pix("pulse_pre", 64, 100, 1'b0, 3'b000);
    drive_pix(64, 100, 1'b1);
    @(posedge clk); #1;
    drive_pix(64, 100, 1'b0);
    check("pulse_t1", rgb_menu, 3'b000);
    @(posedge clk); #1;
    check("pulse_t2", rgb_menu, 3'b100);
    @(posedge clk); #1;
    check("pulse_t3", rgb_menu, 3'b000);

    // Randomized descriptors, blink state and pixels against the model.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 16; a++) begin
        d = 9'($urandom_range(0, 511));
        if ($urandom_range(0, 3) != 0) d[7] = 1'b1;
        write_desc(a, d);
      end
      n = $urandom_range(0, 40);
      for (int f = 0; f < n; f++) frame_pulse();
      for (int p = 0; p < 40; p++) begin
        x = $urandom_range(40, 210);
        y = $urandom_range(95, 125);
        v = ($urandom_range(0, 3) != 0);
        check_pix($sformatf("rnd%0d_%0d(%0d,%0d)", r, p, x, y), x, y, v, model_rgb(x, y, v));
      end
    end

    // Mid-stream reset.
    write_desc(0, 9'b0_1_100_1000);
    check_pix("pre_reset", 64, 100, 1'b1, 3'b100);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_mid", rgb_menu, 3'b000);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("reset_after1", rgb_menu, 3'b000);
    @(posedge clk); #1;
    check("reset_after2", rgb_menu, 3'b000);
    for (int k = 0; k < 8; k++)
      check_pix($sformatf("dark%0d", k), 75 + 16 * k, 103, 1'b1, 3'b000);
    check_pix("dark_a0", 64, 100, 1'b1, 3'b000);
    write_desc(0, 9'b1_1_010_0000);
    check_pix("rewrite", 64, 100, 1'b1, 3'b010);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
